// File: rtl/alu_stack_issuer.sv
// alu_stack_issuer: Forth data-stack front end for a combinational ALU.
// Executes PUSH/DROP/DUP in one cycle and runs EXEC (binary primitive) as
// IDLE -> ISSUE (alu_ena for ALU_LAT cycles) -> WB (pop 2, push result).
// TOS lives in its own register; r_mem holds the entries below it, so NOS
// is r_mem[depth-2] and a push spills the old TOS into r_mem[depth-1].
module alu_stack_issuer #(
  parameter int W       = 8,
  parameter int DEPTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_opcode,
  input  logic [W-1:0]             cmd_data,
  output logic                     alu_ena,
  output logic [7:0]               alu_opcode,
  output logic [W-1:0]             alu_oper0,
  output logic [W-1:0]             alu_oper1,
  input  logic [W-1:0]             alu_data_bus,
  output logic [W-1:0]             tos,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     res_valid,
  output logic                     err_underflow,
  output logic                     err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE  = (PW+1)'(1);
  localparam logic [PW:0]   TWO  = (PW+1)'(2);
  localparam logic [CW-1:0] LAST = CW'(ALU_LAT - 1);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_EXEC = 2'b01;
  localparam logic [1:0] OP_DROP = 2'b10;
  localparam logic [1:0] OP_DUP  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_lat_cnt;
  logic [W-1:0]    r_mem [DEPTH];
  logic [PW:0]     r_depth;
  logic [W-1:0]    r_tos;
  logic [W-1:0]    r_result;
  logic [7:0]      r_alu_opcode;
  logic [W-1:0]    r_alu_oper0;
  logic [W-1:0]    r_alu_oper1;
  logic            r_res_valid;
  logic            r_err_underflow;
  logic            r_err_overflow;

  logic            w_ena;
  logic            w_capture;
  logic            w_wb;
  logic            w_accept;
  logic            w_empty;
  logic            w_full;
  logic            w_lt2;
  logic [PW-1:0]   w_sp1;
  logic [PW-1:0]   w_sp2;
  logic            w_do_push;
  logic            w_do_pop;
  logic            w_do_dup;
  logic            w_do_exec;
  logic            w_spill;
  logic            w_uflow;
  logic            w_oflow;

  // Commands are only taken in IDLE, and never while reset is held.
  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_empty = (r_depth == '0);
  assign w_full  = (r_depth == FULL);
  assign w_lt2   = (r_depth < TWO);
  assign w_sp1   = PW'(r_depth - ONE);   // slot receiving the spilled TOS
  assign w_sp2   = PW'(r_depth - TWO);   // NOS slot

  // Full/empty are resolved before any pointer move, so depth never wraps.
  assign w_do_push = w_accept && (cmd_op == OP_PUSH) && !w_full;
  assign w_do_pop  = w_accept && (cmd_op == OP_DROP) && !w_empty;
  assign w_do_dup  = w_accept && (cmd_op == OP_DUP)  && !w_empty && !w_full;
  assign w_do_exec = w_accept && (cmd_op == OP_EXEC) && !w_lt2;
  assign w_spill   = (w_do_push && !w_empty) || w_do_dup;

  // Underflow wins over overflow for DUP.
  assign w_uflow = w_accept && ((((cmd_op == OP_DROP) || (cmd_op == OP_DUP)) && w_empty) ||
                                ((cmd_op == OP_EXEC) && w_lt2));
  assign w_oflow = w_accept && (((cmd_op == OP_PUSH) && w_full) ||
                                ((cmd_op == OP_DUP) && !w_empty && w_full));

  // FSM state register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and per-state controls.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next    = r_state;
    w_ena     = 1'b0;
    w_capture = 1'b0;
    w_wb      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_do_exec) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_ena = 1'b1;
        if (r_lat_cnt == LAST) begin
          w_capture = 1'b1;
          w_next    = S_WB;
        end
      end
      S_WB: begin
        w_wb   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign alu_ena = w_ena && !rst;

  // Counts enable cycles within ISSUE; the last one triggers capture.
  always_ff @(posedge clk) begin
    if (rst)                                          r_lat_cnt <= '0;
    else if ((r_state == S_ISSUE) && (r_lat_cnt != LAST)) r_lat_cnt <= r_lat_cnt + CW'(1);
    else                                              r_lat_cnt <= '0;
  end

  // Operand/opcode latch at EXEC accept; held stable through ISSUE and afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_opcode <= '0;
      r_alu_oper0  <= '0;
      r_alu_oper1  <= '0;
    end else if (w_do_exec) begin
      r_alu_opcode <= cmd_opcode;
      r_alu_oper0  <= r_mem[w_sp2];
      r_alu_oper1  <= r_tos;
    end
  end

  // Result capture on the edge that ends the final enable cycle.
  always_ff @(posedge clk) begin
    if (w_capture) r_result <= alu_data_bus;
  end

  // Entries below TOS; a push or DUP spills the current TOS one slot up.
  // NOTE: storage array has no reset; r_depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && w_spill) r_mem[w_sp1] <= r_tos;
  end

  // Depth and TOS update; WB cannot overlap an accepted command since cmd_ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
      r_tos   <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + ONE;
      r_tos   <= cmd_data;
    end else if (w_do_dup) begin
      r_depth <= r_depth + ONE;
    end else if (w_do_pop) begin
      r_depth <= r_depth - ONE;
      r_tos   <= w_lt2 ? '0 : r_mem[w_sp2];
    end else if (w_wb) begin
      r_depth <= r_depth - ONE;
      r_tos   <= r_result;
    end
  end

  // One-cycle status pulses, registered so they line up with the new stack state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid     <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_res_valid     <= w_wb;
      r_err_underflow <= w_uflow;
      r_err_overflow  <= w_oflow;
    end
  end

  assign alu_opcode    = r_alu_opcode;
  assign alu_oper0     = r_alu_oper0;
  assign alu_oper1     = r_alu_oper1;
  assign tos           = r_tos;
  assign depth         = r_depth;
  assign res_valid     = r_res_valid;
  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_alu_stack_issuer.sv
// Directed bench for alu_stack_issuer. Three instances share clock, reset and
// command fields but have private cmd_valid: "a" default, "b" DEPTH=4, "c" ALU_LAT=3.
module tb_alu_stack_issuer;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] DROP = 2'b10;
  localparam logic [1:0] DUP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] v;
  logic [1:0] op;
  logic [7:0] opc;
  logic [7:0] dat;

  wire  [2:0] rdy, ena, rv, eu, eo;
  wire  [7:0] aop   [3];
  wire  [7:0] o0    [3];
  wire  [7:0] o1    [3];
  wire  [7:0] tos_w [3];
  wire  [7:0] bus   [3];
  wire  [4:0] dep_a, dep_c;
  wire  [2:0] dep_b;

  int n_assert = 0;
  int n_fail   = 0;
  int ena_cnt [3] = '{0, 0, 0};
  int rv_cnt  [3] = '{0, 0, 0};
  int run_c     = 0;
  int max_run_c = 0;

  always #5 clk = ~clk;

  // Reference ALU: 07 = ADD, anything else = SUB, both truncated to 8 bits.
  function automatic logic [7:0] alu_f(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    return (c == 8'h07) ? a + b : a - b;
  endfunction

  assign bus[0] = alu_f(aop[0], o0[0], o1[0]);
  assign bus[1] = alu_f(aop[1], o0[1], o1[1]);
  // Junk on the bus except in the third enable cycle of instance c.
  assign bus[2] = (ena[2] && run_c == 3) ? alu_f(aop[2], o0[2], o1[2]) : 8'hEE;

  alu_stack_issuer #(.W(8), .DEPTH(16), .ALU_LAT(1)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(v[0]), .cmd_ready(rdy[0]), .cmd_op(op),
    .cmd_opcode(opc), .cmd_data(dat), .alu_ena(ena[0]), .alu_opcode(aop[0]),
    .alu_oper0(o0[0]), .alu_oper1(o1[0]), .alu_data_bus(bus[0]), .tos(tos_w[0]),
    .depth(dep_a), .res_valid(rv[0]), .err_underflow(eu[0]), .err_overflow(eo[0]));

  alu_stack_issuer #(.W(8), .DEPTH(4), .ALU_LAT(1)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(v[1]), .cmd_ready(rdy[1]), .cmd_op(op),
    .cmd_opcode(opc), .cmd_data(dat), .alu_ena(ena[1]), .alu_opcode(aop[1]),
    .alu_oper0(o0[1]), .alu_oper1(o1[1]), .alu_data_bus(bus[1]), .tos(tos_w[1]),
    .depth(dep_b), .res_valid(rv[1]), .err_underflow(eu[1]), .err_overflow(eo[1]));

  alu_stack_issuer #(.W(8), .DEPTH(16), .ALU_LAT(3)) u_c (
    .clk(clk), .rst(rst), .cmd_valid(v[2]), .cmd_ready(rdy[2]), .cmd_op(op),
    .cmd_opcode(opc), .cmd_data(dat), .alu_ena(ena[2]), .alu_opcode(aop[2]),
    .alu_oper0(o0[2]), .alu_oper1(o1[2]), .alu_data_bus(bus[2]), .tos(tos_w[2]),
    .depth(dep_c), .res_valid(rv[2]), .err_underflow(eu[2]), .err_overflow(eo[2]));

  // Negedge monitors: enable/result counts and longest enable run on instance c.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ena_cnt[i] += int'(ena[i]);
      rv_cnt[i]  += int'(rv[i]);
    end
    if (ena[2]) run_c++;
    else        run_c = 0;
    if (run_c > max_run_c) max_run_c = run_c;
  end

  function automatic int g_tos(input int s); return int'(tos_w[s]); endfunction
  function automatic int g_rdy(input int s); return int'(rdy[s]);   endfunction
  function automatic int g_ena(input int s); return int'(ena[s]);   endfunction
  function automatic int g_rv (input int s); return int'(rv[s]);    endfunction
  function automatic int g_eu (input int s); return int'(eu[s]);    endfunction
  function automatic int g_eo (input int s); return int'(eo[s]);    endfunction
  function automatic int g_o0 (input int s); return int'(o0[s]);    endfunction
  function automatic int g_o1 (input int s); return int'(o1[s]);    endfunction
  function automatic int g_aop(input int s); return int'(aop[s]);   endfunction
  function automatic int g_dep(input int s);
    case (s)
      0:       return int'(dep_a);
      1:       return int'(dep_b);
      default: return int'(dep_c);
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int s, input logic [1:0] o, input logic [7:0] c, input logic [7:0] d);
    int n;
    op = o; opc = c; dat = d; v[s] = 1'b1;
    n = 0;
    while (rdy[s] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", g_rdy(s), 1);
    @(negedge clk);
    v[s] = 1'b0;
  endtask

  task automatic do_reset();
    v = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_low", g_rdy(0), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_stack(input string tag, input int s, input int t, input int d);
    check({tag, "_tos"}, g_tos(s), t);
    check({tag, "_depth"}, g_dep(s), d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, r0;
    v = '0; op = PUSH; opc = 8'h00; dat = 8'h00; rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state
    check("reset_ready", g_rdy(0), 1);
    check("reset_ena", int'(ena), 0);
    check("reset_pulses", int'({rv, eu, eo}), 0);
    expect_stack("reset", 0, 0, 0);
    check("reset_oper", g_o0(0) + g_o1(0) + g_aop(0), 0);

    // 1: PUSH 2, PUSH 3, EXEC ADD with exact latency
    send(0, PUSH, 8'h00, 8'd2); expect_stack("t1_p2", 0, 2, 1);
    send(0, PUSH, 8'h00, 8'd3); expect_stack("t1_p3", 0, 3, 2);
    e0 = ena_cnt[0];
    send(0, EXEC, 8'h07, 8'h00);
    check("t1_ena_T", g_ena(0), 1);
    check("t1_oper0", g_o0(0), 2);
    check("t1_oper1", g_o1(0), 3);
    check("t1_opcode", g_aop(0), 'h07);
    check("t1_busy", g_rdy(0), 0);
    @(negedge clk);
    check("t1_ena_wb", g_ena(0), 0);
    check("t1_rv_early", g_rv(0), 0);
    @(negedge clk);
    check("t1_rv", g_rv(0), 1);
    check("t1_ready_back", g_rdy(0), 1);
    expect_stack("t1_res", 0, 5, 1);
    @(negedge clk);
    check("t1_rv_pulse", g_rv(0), 0);
    check("t1_opcode_hold", g_aop(0), 'h07);
    check("t1_ena_cycles", ena_cnt[0] - e0, 1);

    // 2: EXEC with one entry, then DROP past empty
    do_reset();
    send(0, PUSH, 8'h00, 8'd9);
    e0 = ena_cnt[0];
    send(0, EXEC, 8'h07, 8'h00);
    check("t2_uflow", g_eu(0), 1);
    check("t2_oflow", g_eo(0), 0);
    check("t2_ready", g_rdy(0), 1);
    expect_stack("t2_keep", 0, 9, 1);
    @(negedge clk);
    check("t2_uflow_pulse", g_eu(0), 0);
    @(negedge clk);
    check("t2_no_ena", ena_cnt[0] - e0, 0);
    send(0, DROP, 8'h00, 8'h00);
    check("t2_drop1_uflow", g_eu(0), 0);
    expect_stack("t2_drop1", 0, 0, 0);
    send(0, DROP, 8'h00, 8'h00);
    check("t2_drop2_uflow", g_eu(0), 1);
    check("t2_drop2_depth", g_dep(0), 0);
    send(0, DUP, 8'h00, 8'h00);
    check("t2_dup_empty_uflow", g_eu(0), 1);
    check("t2_dup_empty_oflow", g_eo(0), 0);

    // 3: DEPTH=4 overflow on PUSH and DUP, contents survive
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(1, PUSH, 8'h00, 8'(i));
      check("t3_push_no_oflow", g_eo(1), 0);
    end
    send(1, PUSH, 8'h00, 8'd5);
    check("t3_push5_oflow", g_eo(1), 1);
    expect_stack("t3_full", 1, 4, 4);
    send(1, DUP, 8'h00, 8'h00);
    check("t3_dup_oflow", g_eo(1), 1);
    check("t3_dup_uflow", g_eu(1), 0);
    expect_stack("t3_dup", 1, 4, 4);
    send(1, DROP, 8'h00, 8'h00);
    expect_stack("t3_drop", 1, 3, 3);

    // 4: ALU_LAT=3, junk before the last enable cycle must not be captured
    do_reset();
    send(2, PUSH, 8'h00, 8'd2);
    send(2, PUSH, 8'h00, 8'd3);
    e0 = ena_cnt[2];
    send(2, EXEC, 8'h07, 8'h00);
    r0 = 0;
    while (rdy[2] !== 1'b1 && r0 < 10) begin
      r0++;
      @(negedge clk);
    end
    check("t4_ready_low_cycles", r0, 4);
    check("t4_rv", g_rv(2), 1);
    expect_stack("t4_res", 2, 5, 1);
    @(negedge clk);
    check("t4_ena_cycles", ena_cnt[2] - e0, 3);
    check("t4_ena_consecutive", max_run_c, 3);

    // 5: reset during ISSUE
    do_reset();
    send(0, PUSH, 8'h00, 8'd2);
    send(0, PUSH, 8'h00, 8'd3);
    r0 = rv_cnt[0];
    send(0, EXEC, 8'h07, 8'h00);
    check("t5_in_issue", g_ena(0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ena_off", g_ena(0), 0);
    check("t5_ready_in_rst", g_rdy(0), 0);
    check("t5_rv", g_rv(0), 0);
    expect_stack("t5_cleared", 0, 0, 0);
    check("t5_oper_cleared", g_o0(0) + g_o1(0), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", g_rdy(0), 1);
    @(negedge clk);
    check("t5_no_result", rv_cnt[0] - r0, 0);
    check("t5_depth_after", g_dep(0), 0);

    // 6: back-to-back PUSH 7, DUP, EXEC with cmd_valid held
    do_reset();
    r0 = rv_cnt[0];
    send(0, PUSH, 8'h00, 8'd7); expect_stack("t6_push", 0, 7, 1);
    send(0, DUP, 8'h00, 8'h00); expect_stack("t6_dup", 0, 7, 2);
    send(0, EXEC, 8'h07, 8'h00);
    check("t6_oper0", g_o0(0), 7);
    check("t6_oper1", g_o1(0), 7);
    @(negedge clk);
    @(negedge clk);
    check("t6_rv", g_rv(0), 1);
    expect_stack("t6_res", 0, 14, 1);
    repeat (3) @(negedge clk);
    check("t6_one_result", rv_cnt[0] - r0, 1);
    check("t6_depth_stable", g_dep(0), 1);

    // Deeper stack ordering, non-ADD opcode and 8-bit truncation
    do_reset();
    send(0, PUSH, 8'h00, 8'd200);
    send(0, PUSH, 8'h00, 8'd5);
    send(0, PUSH, 8'h00, 8'd9);
    send(0, EXEC, 8'h02, 8'h00);
    check("t7_sub_opcode", g_aop(0), 'h02);
    repeat (2) @(negedge clk);
    expect_stack("t7_sub", 0, 'hFC, 2);
    send(0, EXEC, 8'h07, 8'h00);
    check("t7_add_oper0", g_o0(0), 200);
    check("t7_add_oper1", g_o1(0), 'hFC);
    repeat (2) @(negedge clk);
    expect_stack("t7_add_wrap", 0, 'hC4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
